// File: rtl/avalon_dram_arbiter.sv
// avalon_dram_arbiter: round-robin share of one Avalon-MM DRAM master between two requesters, with in-order read return routing
module avalon_dram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int MAX_PEND = 8,
    parameter int PEND_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic              s0_readdatavalid,
    output logic [DATA_W-1:0] s0_readdata,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic              s1_readdatavalid,
    output logic [DATA_W-1:0] s1_readdata,
    output logic [ADDR_W-1:0] m0_address,
    output logic              m0_read,
    output logic              m0_write,
    output logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_waitrequest,
    input  logic              m0_readdatavalid,
    input  logic [DATA_W-1:0] m0_readdata,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              err_orphan
);
    localparam int PTR_W = MAX_PEND > 1 ? $clog2(MAX_PEND) : 1;
    localparam logic [PEND_W-1:0] MAX_CNT = PEND_W'(MAX_PEND);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(MAX_PEND - 1);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t state;
    logic last_grant, g0, g1, sel_rd, sel_wr, accept, push, pop, head, elig0, elig1;
    logic [MAX_PEND-1:0] owner;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    always_comb begin
        g0 = state == GRANT0;
        g1 = state == GRANT1;
        sel_rd = g0 ? s0_read : g1 ? s1_read : 1'b0;
        sel_wr = g0 ? s0_write : g1 ? s1_write : 1'b0;
        m0_address = g0 ? s0_address : g1 ? s1_address : '0;
        m0_writedata = g0 ? s0_writedata : g1 ? s1_writedata : '0;
        m0_write = sel_wr;
        m0_read = sel_rd & !sel_wr;
        s0_waitrequest = g0 ? m0_waitrequest : 1'b1;
        s1_waitrequest = g1 ? m0_waitrequest : 1'b1;
        accept = (m0_read | m0_write) & !m0_waitrequest;
        push = accept & m0_read;
        pop = m0_readdatavalid & (pend_cnt != '0);
        head = owner[rd_ptr];
        s0_readdatavalid = pop & !head;
        s1_readdatavalid = pop & head;
        s0_readdata = m0_readdata;
        s1_readdata = m0_readdata;
        elig0 = s0_write | (s0_read & (pend_cnt < MAX_CNT));
        elig1 = s1_write | (s1_read & (pend_cnt < MAX_CNT));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last_grant <= 1'b1;
            owner <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            pend_cnt <= '0;
            err_orphan <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 && (!elig1 || last_grant)) state <= GRANT0;
                    else if (elig1) state <= GRANT1;
                end
                GRANT0, GRANT1: begin
                    if (accept) begin
                        state <= IDLE;
                        last_grant <= g1;
                    end else if (!(sel_rd || sel_wr)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (push) begin
                owner[wr_ptr] <= g1;
                wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            pend_cnt <= pend_cnt + PEND_W'(push) - PEND_W'(pop);
            if (m0_readdatavalid && pend_cnt == '0) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avalon_dram_arbiter.sv
// tb_avalon_dram_arbiter: directed vector table plus hand sequences for stalls, full FIFO, orphan and fairness
module tb_avalon_dram_arbiter;
    logic clk = 1'b0, reset = 1'b0;
    logic [31:0] s0_address = '0, s1_address = '0, m0_address;
    logic s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [255:0] s0_writedata = '0, s1_writedata = '0, m0_writedata, m0_readdata = '0;
    logic [255:0] s0_readdata, s1_readdata;
    logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic m0_read, m0_write, m0_waitrequest = 1'b0, m0_readdatavalid = 1'b0;
    logic [3:0] pend_cnt;
    logic err_orphan;
    int n_vec = 0, n_bad = 0;

    avalon_dram_arbiter dut (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write), .s0_writedata(s0_writedata),
        .s0_waitrequest(s0_waitrequest), .s0_readdatavalid(s0_readdatavalid), .s0_readdata(s0_readdata),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdatavalid(s1_readdatavalid), .s1_readdata(s1_readdata),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
        .pend_cnt(pend_cnt), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [31:0] a0, a1;
        logic rdv;
        logic [7:0] d;
        logic [1:0] rw;
        logic [31:0] ea;
        logic [3:0] ws;
        logic [3:0] ep;
    } vec_t;
    vec_t tbl[20];

    function automatic vec_t mk(logic [3:0] req, logic [31:0] a0, a1, logic rdv, logic [7:0] d,
                                logic [1:0] rw, logic [31:0] ea, logic [3:0] ws, logic [3:0] ep);
        vec_t v;
        v.req = req; v.a0 = a0; v.a1 = a1; v.rdv = rdv; v.d = d;
        v.rw = rw; v.ea = ea; v.ws = ws; v.ep = ep;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int n, output logic ok);
        logic g;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            g = (n == 0) ? !s0_waitrequest : !s1_waitrequest;
            tick();
            ok = g;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok, leak, g;
        int cnt, who[20], cyc[20], n;
        logic [255:0] wd;
        // requests: {s0r, s0w, s1r, s1w}; waits/valids: {s0w, s1w, s0v, s1v}
        tbl[0]  = mk(4'b0000, 32'h0,  32'h0,  0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);
        tbl[1]  = mk(4'b1010, 32'h0,  32'h20, 0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);
        tbl[2]  = mk(4'b1010, 32'h0,  32'h20, 0, 8'h00, 2'b10, 32'h0,  4'b0100, 4'd0);
        tbl[3]  = mk(4'b0010, 32'h0,  32'h20, 0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd1);
        tbl[4]  = mk(4'b0010, 32'h0,  32'h20, 0, 8'h00, 2'b10, 32'h20, 4'b1000, 4'd1);
        tbl[5]  = mk(4'b0000, 32'h0,  32'h0,  1, 8'hAA, 2'b00, 32'h0,  4'b1110, 4'd2);
        tbl[6]  = mk(4'b0000, 32'h0,  32'h0,  1, 8'hBB, 2'b00, 32'h0,  4'b1101, 4'd1);
        tbl[7]  = mk(4'b0000, 32'h0,  32'h0,  0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);
        tbl[8]  = mk(4'b1100, 32'h40, 32'h0,  0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);
        tbl[9]  = mk(4'b1100, 32'h40, 32'h0,  0, 8'h00, 2'b01, 32'h40, 4'b0100, 4'd0);
        tbl[10] = mk(4'b0000, 32'h0,  32'h0,  0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);
        tbl[11] = mk(4'b0001, 32'h0,  32'h80, 0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);
        tbl[12] = mk(4'b0000, 32'h0,  32'h80, 0, 8'h00, 2'b00, 32'h80, 4'b1000, 4'd0);
        tbl[13] = mk(4'b1010, 32'hC0, 32'hE0, 0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);
        tbl[14] = mk(4'b1010, 32'hC0, 32'hE0, 0, 8'h00, 2'b10, 32'hE0, 4'b1000, 4'd0);
        tbl[15] = mk(4'b1000, 32'hC0, 32'h0,  0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd1);
        tbl[16] = mk(4'b1000, 32'hC0, 32'h0,  0, 8'h00, 2'b10, 32'hC0, 4'b0100, 4'd1);
        tbl[17] = mk(4'b0000, 32'h0,  32'h0,  1, 8'h11, 2'b00, 32'h0,  4'b1101, 4'd2);
        tbl[18] = mk(4'b0000, 32'h0,  32'h0,  1, 8'h22, 2'b00, 32'h0,  4'b1110, 4'd1);
        tbl[19] = mk(4'b0000, 32'h0,  32'h0,  0, 8'h00, 2'b00, 32'h0,  4'b1100, 4'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 0, {m0_read, m0_write, m0_address, s0_waitrequest, s1_waitrequest,
              s0_readdatavalid, s1_readdatavalid, pend_cnt, err_orphan},
              {2'b00, 32'h0, 4'b1100, 4'd0, 1'b0});
        tick();
        reset = 1'b1;

        foreach (tbl[i]) begin
            {s0_read, s0_write, s1_read, s1_write} = tbl[i].req;
            s0_address = tbl[i].a0;
            s1_address = tbl[i].a1;
            s0_writedata = {8{tbl[i].a0}};
            s1_writedata = {8{tbl[i].a1}};
            m0_readdatavalid = tbl[i].rdv;
            m0_readdata = {32{tbl[i].d}};
            @(negedge clk);
            check("vector", i, {m0_read, m0_write, m0_address, s0_waitrequest, s1_waitrequest,
                  s0_readdatavalid, s1_readdatavalid, pend_cnt, err_orphan},
                  {tbl[i].rw, tbl[i].ea, tbl[i].ws, tbl[i].ep, 1'b0});
            check("readdata", i, 64'(s0_readdata == {32{tbl[i].d}} && s1_readdata == {32{tbl[i].d}}), 64'd1);
            tick();
        end
        {s0_read, s0_write, s1_read, s1_write} = 4'b0000;
        m0_readdatavalid = 1'b0;

        // fill the owner FIFO from s0, then show writes still pass while reads are held off
        for (int i = 0; i < 8; i++) begin
            s0_read = 1'b1;
            s0_address = 32'(i * 32'h20);
            wait_grant(0, ok);
            s0_read = 1'b0;
            check("fill_grant", i, 64'(ok), 64'd1);
        end
        check("full_pend", 0, 64'(pend_cnt), 64'd8);
        s0_read = 1'b1;
        s0_address = 32'h1000;
        s1_write = 1'b1;
        s1_address = 32'h2000;
        leak = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!s0_waitrequest) leak = 1'b1;
            g = !s1_waitrequest;
            if (g) cnt++;
            tick();
            if (g) s1_write = 1'b0;
        end
        check("full_no_read", 0, 64'(leak), 64'd0);
        check("full_write_ok", 0, 64'(cnt), 64'd1);
        check("full_pend_hold", 0, 64'(pend_cnt), 64'd8);
        m0_readdatavalid = 1'b1;
        m0_readdata = {32{8'h5A}};
        @(negedge clk);
        check("full_pop", 0, 64'({s0_readdatavalid, s1_readdatavalid}), 64'b10);
        tick();
        m0_readdatavalid = 1'b0;
        wait_grant(0, ok);
        s0_read = 1'b0;
        check("ninth_grant", 0, 64'(ok), 64'd1);
        check("ninth_pend", 0, 64'(pend_cnt), 64'd8);
        m0_readdatavalid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s0_readdatavalid && !s1_readdatavalid) cnt++;
            tick();
        end
        m0_readdatavalid = 1'b0;
        check("drain_beats", 0, 64'(cnt), 64'd8);
        check("drain_pend", 0, 64'(pend_cnt), 64'd0);

        // write held by slave stall for 5 cycles
        wd = {8{32'hDEADBEEF}};
        m0_waitrequest = 1'b1;
        s0_write = 1'b1;
        s0_address = 32'h100;
        s0_writedata = wd;
        tick();
        s1_write = 1'b1;
        s1_address = 32'h200;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(m0_write && !m0_read && m0_address == 32'h100 && m0_writedata == wd &&
                  s0_waitrequest && s1_waitrequest)) ok = 1'b0;
            tick();
        end
        check("stall_stable", 0, 64'(ok), 64'd1);
        m0_waitrequest = 1'b0;
        cnt = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g = !s1_waitrequest;
            if (!s0_waitrequest && m0_write && m0_address == 32'h100) cnt++;
            if (g) n++;
            tick();
            if (cnt > 0) s0_write = 1'b0;
            if (g) s1_write = 1'b0;
        end
        check("stall_one_xfer", 0, 64'(cnt), 64'd1);
        check("stall_s1_after", 0, 64'(n), 64'd1);

        // orphan beat, then async reset clears it
        m0_readdatavalid = 1'b1;
        @(negedge clk);
        check("orphan_no_valid", 0, 64'({s0_readdatavalid, s1_readdatavalid}), 64'd0);
        tick();
        m0_readdatavalid = 1'b0;
        check("orphan_set", 0, 64'({err_orphan, pend_cnt}), 64'({1'b1, 4'd0}));
        repeat (3) tick();
        check("orphan_sticky", 0, 64'(err_orphan), 64'd1);
        reset = 1'b0;
        #1;
        check("orphan_reset", 0, 64'({err_orphan, pend_cnt, s0_waitrequest, s1_waitrequest}),
              64'({1'b0, 4'd0, 2'b11}));
        tick();
        reset = 1'b1;

        // continuous writes from both sides must alternate every 2 cycles
        s0_write = 1'b1;
        s1_write = 1'b1;
        s0_address = 32'h3000;
        s1_address = 32'h4000;
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 20; c++) begin
            @(negedge clk);
            if (!s0_waitrequest) begin who[cnt] = 0; cyc[cnt] = c; cnt++; end
            else if (!s1_waitrequest) begin who[cnt] = 1; cyc[cnt] = c; cnt++; end
            tick();
        end
        s0_write = 1'b0;
        s1_write = 1'b0;
        check("rr_count", 0, 64'(cnt), 64'd20);
        for (int k = 0; k < cnt; k++) begin
            check("rr_order", k, 64'(who[k]), 64'(k % 2));
            if (k > 0) check("rr_gap", k, 64'(cyc[k] - cyc[k-1]), 64'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
